lsu_v1: RTL

- Load/store unit directly upstream of the word-wide memory subsystem (RAM plus memory-mapped I/O).
- Accepts one byte-addressed RISC-V load/store request at a time from the core.
- Converts the request to word-address memory accesses.
- Performs read-modify-write for byte and halfword stores, because memory has only a whole-word write enable.
- Extracts and sign- or zero-extends load data, then reports completion to the core with a one-cycle done pulse.

---
 rtl/lsu_v1_if.sv | 32 +++
 rtl/lsu_v1.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lsu_v1_if.sv
// Core request/response and word-memory signals of the load/store unit.
// The master side is the core plus memory; the slave side is the LSU.
interface lsu_v1_if #(
    parameter int unsigned addr_width = 10
);
    logic                  req;
    logic                  ready;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [31:0]           rdata;
    logic                  done;
    logic                  err;
    logic [addr_width-1:0] mem_addr;
    logic [31:0]           mem_data_out;
    logic [31:0]           mem_data_in;
    logic                  mem_write_enable;
    logic                  mem_read_enable;

    modport master (
        output req, is_store, funct3, addr, wdata, mem_data_in,
        input  ready, rdata, done, err, mem_addr, mem_data_out,
               mem_write_enable, mem_read_enable
    );

    modport slave (
        input  req, is_store, funct3, addr, wdata, mem_data_in,
        output ready, rdata, done, err, mem_addr, mem_data_out,
               mem_write_enable, mem_read_enable
    );
endinterface

// File: rtl/lsu_v1.sv
// RV32 load/store unit in front of a word-wide memory: one request at a time,
// read-modify-write for byte/halfword stores, sign/zero extension for loads.
module lsu_v1 #(
    parameter int unsigned addr_width = 10,
    parameter int unsigned data_width = 32,
    parameter int unsigned rd_latency = 1
) (
    input logic      clk,
    input logic      rst,
    lsu_v1_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ISSUE_RD, WAIT_RD, WRITE, RESP} state_t;

    state_t                state, state_next;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [addr_width+1:0] addr_q;
    logic [15:0]           wdata_q;
    logic                  err_q;
    logic [1:0]            cnt;
    logic [data_width-1:0] rdata_q;
    logic [data_width-1:0] mem_data_out_q;
    logic                  req_err;
    logic                  is_sw;
    logic                  rd_last;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [data_width-1:0] load_value;
    logic [data_width-1:0] merged;

    // Illegal width codes and misaligned halfword/word accesses
    always_comb begin
        if (bus.is_store)
            req_err = bus.funct3[2] || (bus.funct3[1:0] == 2'b11);
        else
            req_err = (bus.funct3[1:0] == 2'b11) || (bus.funct3 == 3'b110);
        if (bus.funct3[1:0] == 2'b01 && bus.addr[0])
            req_err = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00)
            req_err = 1'b1;
    end

    assign is_sw   = bus.is_store && (bus.funct3 == 3'b010);
    assign rd_last = (cnt == 2'd1);

    // Load extraction and store merge work directly on the word arriving on the capture edge
    always_comb begin
        lane_byte = bus.mem_data_in[{addr_q[1:0], 3'b000} +: 8];
        lane_half = bus.mem_data_in[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_value = {24'd0, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_value = {16'd0, lane_half};
            default: load_value = bus.mem_data_in;
        endcase
        merged = bus.mem_data_in;
        if (funct3_q[0])
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (req_err)
                        state_next = RESP;
                    else if (is_sw)
                        state_next = WRITE;
                    else
                        state_next = ISSUE_RD;
                end
            end
            ISSUE_RD: state_next = WAIT_RD;
            WAIT_RD:  if (rd_last) state_next = is_store_q ? WRITE : RESP;
            WRITE:    state_next = RESP;
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.ready            = (state == IDLE);
        bus.done             = (state == RESP);
        bus.err              = (state == RESP) && err_q;
        bus.mem_read_enable  = (state == ISSUE_RD);
        bus.mem_write_enable = (state == WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q     <= 1'b0;
            funct3_q       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            err_q          <= 1'b0;
            cnt            <= '0;
            rdata_q        <= '0;
            mem_data_out_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        is_store_q     <= bus.is_store;
                        funct3_q       <= bus.funct3;
                        addr_q         <= bus.addr[addr_width+1:0];
                        wdata_q        <= bus.wdata[15:0];
                        err_q          <= req_err;
                        mem_data_out_q <= bus.wdata;
                    end
                end
                ISSUE_RD: cnt <= 2'(rd_latency);
                WAIT_RD: begin
                    cnt <= cnt - 2'd1;
                    if (rd_last) begin
                        if (is_store_q)
                            mem_data_out_q <= merged;
                        else
                            rdata_q <= load_value;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata        = rdata_q;
    assign bus.mem_addr     = addr_q[addr_width+1:2];
    assign bus.mem_data_out = mem_data_out_q;
endmodule
